// File: rtl/matrix_operand_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared types and constants for the 3x3 matrix operand sequencer and the
// downstream dot-product stage.
//   DIM / ELEMS  : matrix dimension and element count
//   elem_t       : one matrix element
//   pair_t       : packed operand pair {b, a} as consumed by the dot-product stage
//   seq_state_t  : sequencer FSM states
//   elem_index() : row-major element index 3*row+col
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int DATA_W = 16;
  localparam int DIM    = 3;
  localparam int ELEMS  = DIM * DIM;

  typedef logic [DATA_W-1:0] elem_t;

  typedef struct packed {
    elem_t b;
    elem_t a;
  } pair_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } seq_state_t;

  function automatic logic [3:0] elem_index(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'd3) + {2'b00, col};
  endfunction

endpackage

// File: rtl/matrix_operand_sequencer_if.sv
// -----------------------------------------------------------------------------
// matrix_operand_sequencer_if
// Bundles the element-write port, the start/status signals and the streaming
// output handshake of the operand sequencer.
//   slave  : sequencer side (accepts writes/start/out_ready, drives the stream)
//   master : feeder/consumer side
// -----------------------------------------------------------------------------
interface matrix_operand_sequencer_if #(
  parameter int DATA_W = 16
);
  logic                  wr_en;
  logic                  wr_sel;
  logic [3:0]            wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   out_data;
  logic                  out_first;
  logic                  out_last;
  logic [3:0]            out_sel;

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, out_ready,
    output busy, done, out_valid, out_data, out_first, out_last, out_sel
  );

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, out_ready,
    input  busy, done, out_valid, out_data, out_first, out_last, out_sel
  );
endinterface

// File: rtl/matrix_operand_sequencer_index_counter.sv
// -----------------------------------------------------------------------------
// matrix_index_counter
// Nested i (outer) / j / k (inner) counter, each running 0..DIM-1.
//   clk, rst_n : clock, async active-low reset
//   srst       : synchronous clear to the origin (wins over en)
//   en         : advance one step
//   i, j, k    : current indices
//   first/last : k at 0 / k at DIM-1
//   terminal   : all three indices at DIM-1 (next step wraps to origin)
// -----------------------------------------------------------------------------
module matrix_index_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       srst,
  input  logic       en,
  output logic [1:0] i,
  output logic [1:0] j,
  output logic [1:0] k,
  output logic       first,
  output logic       last,
  output logic       terminal
);
  import matrix_pkg::*;

  localparam logic [1:0] LAST_IDX = 2'(DIM - 1);

  logic [1:0] i_r, j_r, k_r;
  logic [1:0] i_nxt_s, j_nxt_s, k_nxt_s;

  // Next-index logic: k carries into j, j carries into i, i wraps to 0.
  always_comb begin
    i_nxt_s = i_r;
    j_nxt_s = j_r;
    k_nxt_s = k_r;
    if (srst) begin
      i_nxt_s = 2'd0;
      j_nxt_s = 2'd0;
      k_nxt_s = 2'd0;
    end else if (en) begin
      if (k_r == LAST_IDX) begin
        k_nxt_s = 2'd0;
        if (j_r == LAST_IDX) begin
          j_nxt_s = 2'd0;
          if (i_r == LAST_IDX) begin
            i_nxt_s = 2'd0;
          end else begin
            i_nxt_s = i_r + 2'd1;
          end
        end else begin
          j_nxt_s = j_r + 2'd1;
        end
      end else begin
        k_nxt_s = k_r + 2'd1;
      end
    end else begin
      i_nxt_s = i_r;
      j_nxt_s = j_r;
      k_nxt_s = k_r;
    end
  end

  // Index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_r <= 2'd0;
      j_r <= 2'd0;
      k_r <= 2'd0;
    end else begin
      i_r <= i_nxt_s;
      j_r <= j_nxt_s;
      k_r <= k_nxt_s;
    end
  end

  assign i        = i_r;
  assign j        = j_r;
  assign k        = k_r;
  assign first    = (k_r == 2'd0);
  assign last     = (k_r == LAST_IDX);
  assign terminal = (i_r == LAST_IDX) && (j_r == LAST_IDX) && (k_r == LAST_IDX);

endmodule

// File: rtl/matrix_operand_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_operand_sequencer
// Buffers 3x3 operand matrices A and B (one element written per cycle while
// idle) and, on start, streams the 27 operand pairs of a 3x3 matrix multiply
// in i/j/k order, each beat tagged with its result slot 3*i+j.
//   clk, reset            : clock, async active-low reset
//   bus.wr_*              : element write (wr_sel 0=A, 1=B; addr 0..8 row-major)
//   bus.start/busy/done   : stream control and status
//   bus.out_valid/ready   : output handshake
//   bus.out_data          : {B element, A element}
//   bus.out_first/last    : first/third pair of a result slot
//   bus.out_sel           : result slot 0..8
// Build option SEQ_B_TRANSPOSED_EN: B is stored pre-transposed, beats carry
// {B[j][k], A[i][k]} instead of {B[k][j], A[i][k]}.
// -----------------------------------------------------------------------------
module matrix_operand_sequencer #(
  parameter int DATA_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  matrix_operand_sequencer_if.slave   bus
);
  import matrix_pkg::*;

  logic [DATA_W-1:0]   a_mem_r [0:ELEMS-1];
  logic [DATA_W-1:0]   b_mem_r [0:ELEMS-1];

  seq_state_t          state_r, state_nxt_s;
  logic                wr_fire_s, xfer_s, load_s, srst_s;
  logic [1:0]          i_s, j_s, k_s;
  logic                first_s, last_s, terminal_s;
  logic [3:0]          a_addr_s, b_addr_s;
  logic [DATA_W-1:0]   a_elem_s, b_elem_s;

  logic                busy_r, done_r, out_valid_r;
  logic                out_first_r, out_last_r, out_term_r;
  logic [2*DATA_W-1:0] out_data_r;
  logic [3:0]          out_sel_r;

  assign wr_fire_s = bus.wr_en && (state_r == IDLE) && (bus.wr_addr <= 4'd8);
  assign xfer_s    = out_valid_r && bus.out_ready;
  // The counter holds the index of the next beat to load: it advances on
  // the start load and on every non-final transfer.
  assign load_s    = ((state_r == IDLE) && bus.start) || (xfer_s && !out_term_r);
  assign srst_s    = (state_r == IDLE) && !bus.start;

  matrix_index_counter u_idx (
    .clk      (clk),
    .rst_n    (reset),
    .srst     (srst_s),
    .en       (load_s),
    .i        (i_s),
    .j        (j_s),
    .k        (k_s),
    .first    (first_s),
    .last     (last_s),
    .terminal (terminal_s)
  );

  // Operand addresses for the beat being loaded.
  always_comb begin
    a_addr_s = elem_index(i_s, k_s);
`ifdef SEQ_B_TRANSPOSED_EN
    b_addr_s = elem_index(j_s, k_s);
`else
    b_addr_s = elem_index(k_s, j_s);
`endif
  end

  // Operand read with write bypass so a write in the start cycle is seen.
  always_comb begin
    a_elem_s = a_mem_r[a_addr_s];
    b_elem_s = b_mem_r[b_addr_s];
    if (wr_fire_s && !bus.wr_sel && (bus.wr_addr == a_addr_s)) begin
      a_elem_s = bus.wr_data;
    end else begin
      a_elem_s = a_mem_r[a_addr_s];
    end
    if (wr_fire_s && bus.wr_sel && (bus.wr_addr == b_addr_s)) begin
      b_elem_s = bus.wr_data;
    end else begin
      b_elem_s = b_mem_r[b_addr_s];
    end
  end

  // Operand buffers; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      if (bus.wr_sel) begin
        b_mem_r[bus.wr_addr] <= bus.wr_data;
      end else begin
        a_mem_r[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = STREAM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      STREAM: begin
        if (xfer_s && out_term_r) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = STREAM;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and registered outputs; beat registers only change on a load,
  // so they hold under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_term_r  <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= 4'd0;
    end else begin
      state_r     <= state_nxt_s;
      busy_r      <= (state_nxt_s == STREAM);
      out_valid_r <= (state_nxt_s == STREAM);
      done_r      <= (state_nxt_s == DONE);
      if (load_s) begin
        out_data_r  <= {b_elem_s, a_elem_s};
        out_sel_r   <= elem_index(i_s, j_s);
        out_first_r <= first_s;
        out_last_r  <= last_s;
        out_term_r  <= terminal_s;
      end else if (state_nxt_s != STREAM) begin
        out_data_r  <= '0;
        out_sel_r   <= 4'd0;
        out_first_r <= 1'b0;
        out_last_r  <= 1'b0;
        out_term_r  <= 1'b0;
      end
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_first = out_first_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_sel   = out_sel_r;

endmodule

// File: tb/tb_matrix_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matrix_operand_sequencer
// Directed bench for matrix_operand_sequencer: identity/1..9 multiply,
// backpressure, ignored writes, mid-stream reset, start while busy and a
// write coinciding with start. Honours SEQ_B_TRANSPOSED_EN.
// -----------------------------------------------------------------------------
module tb_matrix_operand_sequencer;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  matrix_operand_sequencer_if #(.DATA_W(DATA_W)) bus_if ();

  matrix_operand_sequencer #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] a_m [0:8];
  logic [15:0] b_m [0:8];

  logic [31:0] got_data  [0:26];
  logic [5:0]  got_tag   [0:26];
  int beats, done_cyc, done_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int n);
    int i, j, k;
    i = n / 9;
    j = (n / 3) % 3;
    k = n % 3;
`ifdef SEQ_B_TRANSPOSED_EN
    return {b_m[3*j+k], a_m[3*i+k]};
`else
    return {b_m[3*k+j], a_m[3*i+k]};
`endif
  endfunction

  // {sel, first, last}
  function automatic logic [5:0] exp_tag(input int n);
    logic [3:0] sel;
    sel = 4'(3 * (n / 9) + (n / 3) % 3);
    return {sel, (n % 3) == 0, (n % 3) == 2};
  endfunction

  task automatic wr(input logic sel, input logic [3:0] addr, input logic [15:0] data, input bit legal);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_sel  = sel;
    bus_if.wr_addr = addr;
    bus_if.wr_data = data;
    @(negedge clk);
    bus_if.wr_en = 1'b0;
    if (legal) begin
      if (sel) b_m[addr] = data;
      else     a_m[addr] = data;
    end
  endtask

  task automatic run_stream(input string tag, input int stall_at, input int stall_len,
                            input int pulse_at, input int wr_at);
    int cyc, stall_cnt;
    bit pulsed, wr_done;
    beats = 0; done_cyc = -1; done_cnt = 0;
    stall_cnt = 0; pulsed = 1'b0; wr_done = 1'b0;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.wr_en = 1'b0;
    cyc = 1;
    check_eq({tag, "_valid_rise"}, 32'(bus_if.out_valid), 32'd1);
    while (cyc < 150 && (done_cyc < 0 || cyc <= done_cyc + 3)) begin
      bus_if.start = 1'b0;
      bus_if.wr_en = 1'b0;
      if (beats == stall_at && stall_cnt < stall_len) begin
        bus_if.out_ready = 1'b0;
        stall_cnt++;
        check_eq({tag, "_stall_valid"}, 32'(bus_if.out_valid), 32'd1);
        check_eq({tag, "_stall_data"}, bus_if.out_data, exp_data(beats));
        check_eq({tag, "_stall_tag"}, 32'({bus_if.out_sel, bus_if.out_first, bus_if.out_last}),
                 32'(exp_tag(beats)));
      end else begin
        bus_if.out_ready = 1'b1;
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (beats < 27) begin
          got_data[beats] = bus_if.out_data;
          got_tag[beats]  = {bus_if.out_sel, bus_if.out_first, bus_if.out_last};
        end
        beats++;
      end
      if (bus_if.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (beats == pulse_at && !pulsed) begin
        bus_if.start = 1'b1;
        pulsed = 1'b1;
      end
      if (beats == wr_at && !wr_done) begin
        bus_if.wr_en   = 1'b1;
        bus_if.wr_sel  = 1'b0;
        bus_if.wr_addr = 4'd4;
        bus_if.wr_data = 16'h00FF;
        wr_done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    bus_if.start = 1'b0;
    bus_if.wr_en = 1'b0;
    bus_if.out_ready = 1'b1;
    if (done_cyc < 0) check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic verify(input string tag, input int exp_done_cyc);
    check_eq({tag, "_beats"}, 32'(beats), 32'd27);
    check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done_cyc));
    for (int n = 0; n < 27; n++) begin
      check_eq($sformatf("%s_data%0d", tag, n), got_data[n], exp_data(n));
      check_eq($sformatf("%s_tag%0d", tag, n), 32'(got_tag[n]), 32'(exp_tag(n)));
    end
  endtask

  initial begin
    int guard;
    reset = 1'b0;
    bus_if.wr_en = 1'b0;
    bus_if.wr_sel = 1'b0;
    bus_if.wr_addr = 4'd0;
    bus_if.wr_data = 16'd0;
    bus_if.start = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    check_eq("rst_busy",  32'(bus_if.busy), 32'd0);
    check_eq("rst_done",  32'(bus_if.done), 32'd0);
    check_eq("rst_valid", 32'(bus_if.out_valid), 32'd0);
    check_eq("rst_data",  bus_if.out_data, 32'd0);
    check_eq("rst_tag",   32'({bus_if.out_sel, bus_if.out_first, bus_if.out_last}), 32'd0);

    reset = 1'b1;
    @(negedge clk);

    // A = identity, B = 1..9 row-major
    for (int n = 0; n < 9; n++) begin
      wr(1'b0, 4'(n), (n % 4 == 0) ? 16'd1 : 16'd0, 1'b1);
      wr(1'b1, 4'(n), 16'(n + 1), 1'b1);
    end

    // Basic multiply with hand-computed beats
    run_stream("basic", -1, 0, -1, -1);
    check_eq("basic_beat0", got_data[0], 32'h0001_0001);
`ifdef SEQ_B_TRANSPOSED_EN
    check_eq("basic_beat1", got_data[1], 32'h0002_0000);
    check_eq("basic_beat2", got_data[2], 32'h0003_0000);
`else
    check_eq("basic_beat1", got_data[1], 32'h0004_0000);
    check_eq("basic_beat2", got_data[2], 32'h0007_0000);
`endif
    check_eq("basic_tag0",  32'(got_tag[0]), 32'(6'b0000_10));
    check_eq("basic_tag2",  32'(got_tag[2]), 32'(6'b0000_01));
    check_eq("basic_beat26", got_data[26], 32'h0009_0001);
    check_eq("basic_tag26", 32'(got_tag[26]), 32'(6'b1000_01));
    check_eq("basic_done_28", 32'(done_cyc), 32'd28);
    verify("basic", 28);

    // Backpressure: 5 stalled cycles at beat 4
    run_stream("bp", 4, 5, -1, -1);
    verify("bp", 33);

    // Write during streaming is ignored, then out-of-range writes in idle
    run_stream("wrbusy", -1, 0, -1, 6);
    verify("wrbusy", 28);
    wr(1'b0, 4'd12, 16'hBEEF, 1'b0);
    wr(1'b1, 4'd12, 16'hBEEF, 1'b0);
    run_stream("restart", -1, 0, -1, -1);
`ifdef SEQ_B_TRANSPOSED_EN
    check_eq("restart_beat10", got_data[10], 32'h0002_0001);
`else
    check_eq("restart_beat10", got_data[10], 32'h0004_0001);
`endif
    verify("restart", 28);

    // Start pulse while busy is ignored
    run_stream("startbusy", -1, 0, 13, -1);
    verify("startbusy", 28);

    // Asynchronous reset at beat 10
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    beats = 0;
    guard = 0;
    while (beats < 10 && guard < 50) begin
      if (bus_if.out_valid) beats++;
      @(negedge clk);
      guard++;
    end
    check_eq("mid_reached10", 32'(beats), 32'd10);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_busy",  32'(bus_if.busy), 32'd0);
    check_eq("mid_valid", 32'(bus_if.out_valid), 32'd0);
    check_eq("mid_data",  bus_if.out_data, 32'd0);
    check_eq("mid_tag",   32'({bus_if.out_sel, bus_if.out_first, bus_if.out_last}), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("mid_no_done", 32'(bus_if.done), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_idle_done", 32'(bus_if.done), 32'd0);
    check_eq("mid_idle_busy", 32'(bus_if.busy), 32'd0);
    run_stream("replay", -1, 0, -1, -1);
    verify("replay", 28);

    // Write to B[0] in the start cycle is used by beat 0
    bus_if.wr_en   = 1'b1;
    bus_if.wr_sel  = 1'b1;
    bus_if.wr_addr = 4'd0;
    bus_if.wr_data = 16'h0055;
    b_m[0] = 16'h0055;
    run_stream("wrstart", -1, 0, -1, -1);
    check_eq("wrstart_beat0", got_data[0], 32'h0055_0001);
    verify("wrstart", 28);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_operand_sequencer.md
Name: matrix_operand_sequencer

Overview:
Upstream feeder for the 3x3 dot-product stage. It buffers two 3x3 operand matrices, A (left) and B (right), loaded one element per cycle. On start it streams the 27 packed operand pairs that a full 3x3 matrix multiply needs, three pairs per result element. Each beat carries the result slot index that the downstream register bank select uses.

Parameters:
DATA_W, 16, width of one matrix element; the packed output word is 2*DATA_W.
DIM, 3, matrix dimension; the block is only required to work at 3, and other values are unsupported.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
wr_en  in  1  write one element this cycle
wr_sel  in  1  0 = write matrix A, 1 = write matrix B
wr_addr  in  4  row-major element index, 3*row+col, valid range 0..8
wr_data  in  DATA_W  element value
start  in  1  single-cycle pulse that begins streaming
busy  out  1  high while streaming
done  out  1  one-cycle pulse after the last beat is accepted
out_valid  out  1  out_data holds a valid beat
out_ready  in  1  downstream accepts the beat
out_data  out  2*DATA_W  packed pair {B element [31:16], A element [15:0]}
out_first  out  1  first of the 3 pairs for a result slot
out_last  out  1  third of the 3 pairs for a result slot
out_sel  out  4  result slot 3*i+j, range 0..8

Behaviour:
- Reset (reset low, async): FSM goes to IDLE; busy, done, out_valid, out_first and out_last are 0; out_data and out_sel are 0; counters i, j, k are 0. Matrix contents are don't-care after reset; no clear is required.
- Write rules:
  - A write takes effect at the clock edge when wr_en=1, the FSM is in IDLE, and wr_addr<=8.
  - Writes with wr_addr 9..15 are ignored.
  - Writes while busy are ignored; the buffers stay stable during streaming.
- FSM states:
  - IDLE -> STREAM on start=1. If wr_en=1 in the same cycle, the write completes first, so the new value is used.
  - STREAM -> DONE when the beat with i=j=k=2 is accepted.
  - DONE -> IDLE after one cycle; done=1 only during the DONE cycle.
  - start is ignored in STREAM and DONE.
- Streaming:
  - out_valid rises the cycle after start is sampled.
  - Beat order is nested loops i (outer), j, k (inner), each counting 0..2, giving 27 beats.
  - Each beat is out_data={B[k][j],A[i][k]} and out_sel=3*i+j.
  - out_first=(k==0); out_last=(k==2).
- Handshake:
  - A beat transfers when out_valid and out_ready are both 1.
  - While out_valid=1 and out_ready=0, out_data, out_sel, out_first and out_last hold stable.
  - out_valid never drops until the beat transfers.
  - With out_ready tied high: 1 beat per cycle, 27 cycles.
- Counter wrap: k wraps 2->0 and increments j; j wraps 2->0 and increments i. After the final beat the counters return to 0.
- busy=1 from the cycle after start through the final transfer cycle inclusive.
- Reset mid-stream: immediate abort to IDLE with all outputs at their reset values; no done pulse.
- No arithmetic is performed; elements pass through bit-exact.

Optional Feature:
Macro SEQ_B_TRANSPOSED_EN.
- Defined: matrix B is interpreted as pre-transposed and beats carry {B[j][k],A[i][k]}, so both operands walk along rows. This suits the case where the upstream writer produces columns as rows.
- Undefined: beats carry {B[k][j],A[i][k]}, the standard product.
- All other timing is identical in both builds.

Decomposition:
- Package matrix_pkg holds:
  - constants DIM=3 and ELEMS=9;
  - typedef elem_t (logic [DATA_W-1:0]);
  - a packed struct pair_t {elem_t b; elem_t a;} that matches the dot-product input layout;
  - the enum seq_state_t {IDLE, STREAM, DONE}.
- Sub-module matrix_index_counter: the i/j/k nested 0..2 counter with enable, wrap carries, a first/last flag and a terminal flag. It is reusable by the downstream stage.

Test Plan:
- Basic multiply: load A=identity and B=1..9 row-major, start, out_ready=1.
  - Beats 0..2 are 0x0001_0001, 0x0004_0000, 0x0007_0000 with sel=0, first on beat 0 and last on beat 2.
  - Beat 26 is 0x0009_0001 with sel=8.
  - done pulses exactly 28 cycles after start.
- Backpressure: hold out_ready=0 for 5 cycles at beat 4. out_data, out_sel and the flags stay frozen; the total beat count is still 27; no beat is duplicated or dropped.
- Ignored writes: write A[4]=0x00FF during STREAM, then write wr_addr=12. After DONE, a restart streams the original A[4] value; a write with wr_addr 12 leaves every element unchanged.
- Reset mid-stream: assert reset low asynchronously at beat 10. Outputs go to 0 immediately with no done pulse; a new start replays from sel=0, k=0.
- Start while busy: pulse start at beat 13; the sequence is unaffected and done pulses once.
- SEQ_B_TRANSPOSED_EN build: same load as the basic-multiply scenario. Beats 0..2 are 0x0001_0001, 0x0002_0000, 0x0003_0000.
